// File: rtl/aes_word_stream_if.sv
// -----------------------------------------------------------------------------
// aes_word_stream_if
//   The two 32-bit valid/ready word streams around the AES block adapter.
//   slave  : adapter view (consumes s_*, produces m_*)
//   master : environment view (produces s_*, consumes m_*)
//   Signals:
//     s_data  [31:0] input word          s_valid  input word valid
//     s_ready        adapter takes word  s_ende   0=encrypt 1=decrypt (first word)
//     m_data  [31:0] output word         m_valid  output word valid
//     m_ready        downstream takes word
// -----------------------------------------------------------------------------
interface aes_word_stream_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_ende;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport slave (
    input  s_data, s_valid, s_ende, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, s_ende, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/aes_word_stream.sv
// -----------------------------------------------------------------------------
// aes_word_stream
//   Adapter between a 32-bit word stream and a 128-bit AES core. Four input
//   words are packed into one block (first word -> [127:96]), launched with a
//   single-cycle core_data_valid pulse once core and key schedule are ready,
//   and the 128-bit result is streamed back out in the same word order.
//   One block in flight; a watchdog abandons a block whose result never comes.
//
//   Optional feature: define AES_WORD_STREAM_CBC_EN to add CBC chaining
//   (ports iv/iv_load and a 128-bit chain register). Default build is ECB.
//
//   Parameters:
//     TIMEOUT_CYCLES  cycles allowed in WAIT before abort (1..255)
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     strm                  word streams (aes_word_stream_if.slave)
//     key_ready             key expansion complete
//     core_enable           core clock enable (1 from first edge after reset)
//     core_ende             block mode to core, latched with first word
//     core_data[127:0]      block to core
//     core_data_valid       one-cycle launch pulse
//     core_ready            core can take a block next cycle
//     core_result[127:0]    core output block
//     core_result_valid     core result strobe
//     iv[127:0], iv_load    CBC initial vector load (CBC build only)
//     busy                  block between first accepted and last emitted word
//     err_timeout           sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module aes_word_stream #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  aes_word_stream_if.slave      strm,
  input  logic                  key_ready,
  output logic                  core_enable,
  output logic                  core_ende,
  output logic [127:0]          core_data,
  output logic                  core_data_valid,
  input  logic                  core_ready,
  input  logic [127:0]          core_result,
  input  logic                  core_result_valid,
`ifdef AES_WORD_STREAM_CBC_EN
  input  logic [127:0]          iv,
  input  logic                  iv_load,
`endif
  output logic                  busy,
  output logic                  err_timeout
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   word_cnt_q, word_cnt_d;
  logic [127:0] blk_q, blk_d;            // packed input block
  logic [127:0] buf_q, buf_d;            // result block being drained
  logic [127:0] core_data_q, core_data_d;
  logic         core_data_valid_q, core_data_valid_d;
  logic         core_ende_q, core_ende_d;
  logic         core_enable_q;
  logic         m_valid_q, m_valid_d;
  logic [31:0]  m_data_q, m_data_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;
  logic [7:0]   timer_q, timer_d;

  logic [127:0] filled;                  // blk_q with the current word slotted in
  logic [127:0] enc_mask;                // XORed into the block sent to the core
  logic [127:0] dec_mask;                // XORed into the result from the core

  function automatic logic [31:0] word_of(input logic [127:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return b[127:96];
      2'd1:    return b[95:64];
      2'd2:    return b[63:32];
      default: return b[31:0];
    endcase
  endfunction

`ifdef AES_WORD_STREAM_CBC_EN
  logic [127:0] chain_q, chain_d;
  // Encrypt chains on the plaintext side, decrypt on the result side.
  assign enc_mask = core_ende_q ? '0 : chain_q;
  assign dec_mask = core_ende_q ? chain_q : '0;
`else
  assign enc_mask = '0;
  assign dec_mask = '0;
`endif

  always_comb begin
    filled = blk_q;
    case (word_cnt_q)
      2'd0:    filled[127:96] = strm.s_data;
      2'd1:    filled[95:64]  = strm.s_data;
      2'd2:    filled[63:32]  = strm.s_data;
      default: filled[31:0]   = strm.s_data;
    endcase
  end

  // NOTE: every variable gets its hold value before the case statement, so
  // no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    blk_d             = blk_q;
    buf_d             = buf_q;
    core_data_d       = core_data_q;
    core_data_valid_d = 1'b0;
    core_ende_d       = core_ende_q;
    m_valid_d         = m_valid_q;
    m_data_d          = m_data_q;
    busy_d            = busy_q;
    err_d             = err_q;
    timer_d           = timer_q;
`ifdef AES_WORD_STREAM_CBC_EN
    chain_d           = chain_q;
`endif

    case (state_q)
      ST_FILL: begin
`ifdef AES_WORD_STREAM_CBC_EN
        if (iv_load && word_cnt_q == 2'd0) chain_d = iv;
`endif
        // s_ready is 1 throughout FILL, so s_valid alone is the handshake.
        if (strm.s_valid) begin
          blk_d      = filled;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd0) begin
            core_ende_d = strm.s_ende;
            busy_d      = 1'b1;
          end
          if (word_cnt_q == 2'd3) begin
            // Mode was latched on word 0, so core_ende_q is valid here.
            core_data_d = filled ^ enc_mask;
            state_d     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (core_ready && key_ready) begin
          core_data_valid_d = 1'b1;
          timer_d           = '0;
          state_d           = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (core_result_valid) begin
          buf_d     = core_result ^ dec_mask;
          m_valid_d = 1'b1;
          m_data_d  = word_of(core_result ^ dec_mask, 2'd0);
          state_d   = ST_DRAIN;
`ifdef AES_WORD_STREAM_CBC_EN
          chain_d   = core_ende_q ? blk_q : core_result;
`endif
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FILL;
        end
      end

      default: begin // ST_DRAIN: m_valid_q is 1 here
        if (strm.m_ready) begin
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_FILL;
          end else begin
            m_data_d = word_of(buf_q, word_cnt_q + 2'd1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_FILL;
      word_cnt_q        <= '0;
      core_data_q       <= '0;
      core_data_valid_q <= 1'b0;
      core_ende_q       <= 1'b0;
      core_enable_q     <= 1'b0;
      m_valid_q         <= 1'b0;
      m_data_q          <= '0;
      busy_q            <= 1'b0;
      err_q             <= 1'b0;
      timer_q           <= '0;
`ifdef AES_WORD_STREAM_CBC_EN
      chain_q           <= '0;
`endif
    end else begin
      state_q           <= state_d;
      word_cnt_q        <= word_cnt_d;
      core_data_q       <= core_data_d;
      core_data_valid_q <= core_data_valid_d;
      core_ende_q       <= core_ende_d;
      core_enable_q     <= 1'b1;
      m_valid_q         <= m_valid_d;
      m_data_q          <= m_data_d;
      busy_q            <= busy_d;
      err_q             <= err_d;
      timer_q           <= timer_d;
`ifdef AES_WORD_STREAM_CBC_EN
      chain_q           <= chain_d;
`endif
    end
  end

  // NOTE: the block buffers carry no reset; word_cnt and state decide which
  // contents are meaningful, so stale data after reset is never observed.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
    buf_q <= buf_d;
  end

  assign strm.s_ready    = (state_q == ST_FILL);
  assign strm.m_valid    = m_valid_q;
  assign strm.m_data     = m_data_q;
  assign core_enable     = core_enable_q;
  assign core_ende       = core_ende_q;
  assign core_data       = core_data_q;
  assign core_data_valid = core_data_valid_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_aes_word_stream.sv
// -----------------------------------------------------------------------------
// tb_aes_word_stream
//   Random-stimulus bench for aes_word_stream. A stand-in AES core answers
//   the known FIPS-197 vector exactly and uses an invertible scramble for any
//   other block. A block-level model (chain value, expected core input and
//   expected output words) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_aes_word_stream;

  localparam int unsigned TB_TIMEOUT = 8;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] IV    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KMASK = 128'h5a3c96e1_0f1e2d3c_a5b4c3d2_77665544;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_ready, core_ready;
  logic         core_enable, core_ende, core_data_valid;
  logic [127:0] core_data, core_result;
  logic         core_result_valid;
  logic         busy, err_timeout;
`ifdef AES_WORD_STREAM_CBC_EN
  logic [127:0] iv;
  logic         iv_load;
`endif

  aes_word_stream_if strm ();

  aes_word_stream #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .strm              (strm),
    .key_ready         (key_ready),
    .core_enable       (core_enable),
    .core_ende         (core_ende),
    .core_data         (core_data),
    .core_data_valid   (core_data_valid),
    .core_ready        (core_ready),
    .core_result       (core_result),
    .core_result_valid (core_result_valid),
`ifdef AES_WORD_STREAM_CBC_EN
    .iv                (iv),
    .iv_load           (iv_load),
`endif
    .busy              (busy),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] model_chain = '0;
  bit           err_exp     = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b, input int idx);
    return b[127 - 32*idx -: 32];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in core: exact for the known vector, invertible scramble otherwise.
  function automatic logic [127:0] fake_core(input logic dec, input logic [127:0] d);
    logic [127:0] y;
    if (!dec && d == PT) return CT;
    if (dec && d == CT)  return PT;
    if (!dec) return {d[63:0], d[127:64]} ^ KMASK;
    y = d ^ KMASK;
    return {y[63:0], y[127:64]};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, strm.s_ready, 1);
    check({tag, "_core_enable"}, core_enable, 0);
    check({tag, "_core_ende"}, core_ende, 0);
    check({tag, "_core_data"}, core_data, 0);
    check({tag, "_cdv"}, core_data_valid, 0);
    check({tag, "_m_valid"}, strm.m_valid, 0);
    check({tag, "_m_data"}, strm.m_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  // One complete block: fill, launch, core response (or none), drain.
  task automatic run_block(input logic [127:0] blk, input bit ende, input int key_stall,
                           input int mr_stall, input bit expire, output logic [127:0] got);
    logic [127:0] exp_core, exp_out, resp;
    int  sent, guard, lat, idx, stall;
    bit  acc;
    got      = '0;
    exp_core = ende ? blk : (blk ^ model_chain);
    exp_out  = ende ? (fake_core(1'b1, blk) ^ model_chain) : fake_core(1'b0, exp_core);

    // Fill: random gaps, random s_ende on words 2..4, stray result strobes.
    sent = 0;
    guard = 0;
    while (sent < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      core_result_valid = ($urandom_range(0, 7) == 0);
      core_result       = rnd128();
      if ($urandom_range(0, 3) == 0) begin
        strm.s_valid = 1'b0;
        strm.s_data  = $urandom;
        strm.s_ende  = 1'($urandom);
      end else begin
        strm.s_valid = 1'b1;
        strm.s_data  = word_of(blk, sent);
        strm.s_ende  = (sent == 0) ? ende : 1'($urandom);
        if (strm.s_ready) sent++;
      end
    end
    check("fill_words", sent, 4);

    // Issue: key_ready held low for key_stall cycles.
    @(negedge clk);
    strm.s_valid = 1'b0;
    for (int c = 0; c <= key_stall; c++) begin
      if (c > 0) @(negedge clk);
      check("cdv_hold", core_data_valid, 0);
      check("s_ready_issue", strm.s_ready, 0);
      check("busy_issue", busy, 1);
      core_result_valid = ($urandom_range(0, 3) == 0);
      core_result       = rnd128();
      if (c == key_stall) begin
        key_ready  = 1'b1;
        core_ready = 1'b1;
      end else begin
        key_ready  = 1'b0;
        core_ready = 1'($urandom);
      end
    end
    @(negedge clk);
    core_result_valid = 1'b0;
    check("cdv_pulse", core_data_valid, 1);
    check("core_data", core_data, exp_core);
    check("core_ende", core_ende, ende);
    resp = fake_core(core_ende, core_data);

    if (expire) begin
      for (int c = 2; c <= int'(TB_TIMEOUT); c++) begin
        @(negedge clk);
        check("cdv_single", core_data_valid, 0);
        check("err_before_timeout", err_timeout, err_exp);
        check("busy_wait", busy, 1);
      end
      @(negedge clk);
      err_exp = 1'b1;
      check("err_timeout_set", err_timeout, 1);
      check("timeout_s_ready", strm.s_ready, 1);
      check("timeout_busy", busy, 0);
      check("timeout_m_valid", strm.m_valid, 0);
      return;
    end

    lat = $urandom_range(1, 5);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check("cdv_single", core_data_valid, 0);
      check("m_valid_early", strm.m_valid, 0);
    end
    core_result       = resp;
    core_result_valid = 1'b1;
    @(negedge clk);
    core_result_valid = 1'b0;
    core_result       = rnd128();
    check("cdv_single", core_data_valid, 0);
    check("m_valid_latency", strm.m_valid, 1);

    // Drain: m_data must hold the expected word even while stalled.
    idx = 0;
    guard = 0;
    stall = mr_stall;
    while (idx < 4 && guard < 300) begin
      check("m_valid_drain", strm.m_valid, 1);
      check("m_data", strm.m_data, word_of(exp_out, idx));
      check("busy_drain", busy, 1);
      check("s_ready_drain", strm.s_ready, 0);
      check("core_ende_drain", core_ende, ende);
      check("err_drain", err_timeout, err_exp);
      if (stall > 0) begin
        strm.m_ready = 1'b0;
        stall--;
      end else begin
        strm.m_ready = 1'($urandom);
      end
      acc = strm.m_ready;
      if (acc) got = {got[95:0], strm.m_data};
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    strm.m_ready = 1'b0;
    check("drain_words", idx, 4);
    check("m_valid_end", strm.m_valid, 0);
    check("busy_end", busy, 0);
    check("s_ready_end", strm.s_ready, 1);
    check("core_enable", core_enable, 1);
`ifdef AES_WORD_STREAM_CBC_EN
    model_chain = ende ? blk : exp_out;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] got, blk, ct1, ct2;
    reset_n           = 1'b0;
    key_ready         = 1'b1;
    core_ready        = 1'b1;
    core_result       = '0;
    core_result_valid = 1'b0;
    strm.s_data       = '0;
    strm.s_valid      = 1'b0;
    strm.s_ende       = 1'b0;
    strm.m_ready      = 1'b0;
`ifdef AES_WORD_STREAM_CBC_EN
    iv                = '0;
    iv_load           = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("core_enable_after_reset", core_enable, 1);

    // Known-vector encrypt, then decrypt of its ciphertext.
    run_block(PT, 1'b0, 0, 0, 1'b0, got);
    check("kat_encrypt", got, CT);
    run_block(CT, 1'b1, 0, 0, 1'b0, got);

    // key_ready low for 20 cycles after the 4th word.
    run_block(rnd128(), 1'($urandom), 20, 0, 1'b0, got);
    // m_ready low for 10 cycles in DRAIN, then random.
    run_block(rnd128(), 1'($urandom), 0, 10, 1'b0, got);

    // Watchdog abort, then a normal block with the flag still set.
    run_block(rnd128(), 1'b0, 1, 0, 1'b1, got);
    run_block(rnd128(), 1'($urandom), 0, 2, 1'b0, got);

    for (int i = 0; i < 20; i++) begin
      blk = rnd128();
      run_block(blk, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, got);
    end

`ifdef AES_WORD_STREAM_CBC_EN
    @(negedge clk);
    iv = IV;
    iv_load = 1'b1;
    model_chain = IV;
    @(negedge clk);
    iv_load = 1'b0;
    run_block(PT, 1'b0, 0, 0, 1'b0, ct1);
    run_block(PT, 1'b0, 0, 0, 1'b0, ct2);
    check("cbc_ciphertexts_differ", ct1 != ct2, 1);
    @(negedge clk);
    iv_load = 1'b1;
    model_chain = IV;
    @(negedge clk);
    iv_load = 1'b0;
    run_block(ct1, 1'b1, 0, 0, 1'b0, got);
    check("cbc_decrypt_1", got, PT);
    run_block(ct2, 1'b1, 0, 0, 1'b0, got);
    check("cbc_decrypt_2", got, PT);
`endif

    // Reset in the middle of FILL discards the partial block.
    @(negedge clk);
    strm.s_valid = 1'b1;
    strm.s_ende  = 1'b1;
    strm.s_data  = $urandom;
    @(negedge clk);
    strm.s_data  = $urandom;
    @(negedge clk);
    strm.s_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check_reset_values("mid_fill_reset");
    model_chain = '0;
    err_exp     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_block(PT, 1'b0, 0, 1, 1'b0, got);
    check("after_reset_encrypt", got, CT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_word_stream.md
Name: aes_word_stream

Overview:
- Upstream/downstream adapter for the AES core. It converts a 32-bit valid/ready word stream into 128-bit blocks on the core's cipher-bus master side, and converts each 128-bit result back into a 32-bit word stream.
- Handles one block in flight at a time. It issues the core's single-cycle data-valid pulse only when both the core and the key schedule are ready.
- A watchdog aborts a block whose result never arrives.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort; valid range 1..255; counter is 8 bits.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_data  in  32  input word
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts s_data this cycle
- s_ende  in  1  0=encrypt, 1=decrypt; sampled with first word of each block
- m_data  out  32  output word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts m_data
- key_ready  in  1  key expansion complete
- core_enable  out  1  core clock enable
- core_ende  out  1  core mode
- core_data  out  128  block to core
- core_data_valid  out  1  one-cycle launch pulse
- core_ready  in  1  core can take a block next cycle
- core_result  in  128  core output block
- core_result_valid  in  1  core result strobe
- busy  out  1  a block is between first accepted word and last emitted word
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values (reset_n low, asynchronous): FILL state, word_cnt=0, core_data=0, core_data_valid=0, core_ende=0, core_enable=0, m_valid=0, m_data=0, busy=0, err_timeout=0, timer=0.
- After reset deasserts, core_enable is 1 from the next edge onward.
- Word order: first word maps to bits [127:96], last word to [31:0]. Output uses the same order.

FSM:
- FILL
  - s_ready=1.
  - Each s_valid&s_ready handshake stores the word into slot word_cnt and increments word_cnt (2 bits, wraps 3->0).
  - On the word_cnt=0 handshake, latch s_ende into core_ende and set busy=1.
  - On the 4th handshake, go to ISSUE.
- ISSUE
  - s_ready=0.
  - When core_ready & key_ready: drive core_data_valid=1 for exactly one cycle, clear timer, go to WAIT.
  - Otherwise hold; no timeout applies in ISSUE.
- WAIT
  - timer increments each cycle.
  - core_result_valid: capture core_result into the output buffer, go to DRAIN. Takes priority over timeout in the same cycle.
  - timer==TIMEOUT_CYCLES-1 with no result: set err_timeout, clear busy, go to FILL, discard the block.
  - A core_result_valid outside WAIT is ignored.
- DRAIN
  - m_valid=1, m_data=buffer word word_cnt.
  - On m_valid&m_ready: word_cnt++.
  - After the 4th handshake: m_valid=0, busy=0, go to FILL.
  - m_data and m_valid are registered and must not change while m_valid=1 & m_ready=0.

Latency and boundary rules:
- Latency: last input handshake -> core_data_valid is 1 cycle minimum. core_result_valid -> first m_valid is 1 cycle.
- No overlap: s_ready stays 0 from ISSUE through DRAIN.
- core_ende stays constant from ISSUE through DRAIN. s_ende changes mid-block are ignored.
- err_timeout clears only on reset.
- Reset mid-block discards all partial data.

Optional Feature:
- Macro: AES_WORD_STREAM_CBC_EN.
- When defined, adds ports iv (in, 128) and iv_load (in, 1), plus a 128-bit chain register (reset 0).
  - iv_load is accepted only in FILL with word_cnt=0; it loads chain<=iv. Elsewhere it is ignored.
  - Encrypt: core_data = packed block ^ chain; on result, chain<=core_result.
  - Decrypt: output buffer = core_result ^ chain; chain<=packed ciphertext block.
  - A timeout leaves chain unchanged.
- When not defined: plain ECB, no iv ports, no chain register.

Test Plan:
- AES-128 encrypt (key 000102..0f loaded), words 00112233,44556677,8899aabb,ccddeeff -> one core_data_valid pulse with core_data=00112233445566778899aabbccddeeff; outputs 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order.
- Decrypt of that ciphertext with s_ende=1 on first word -> output 00112233,44556677,8899aabb,ccddeeff. Toggling s_ende on words 2-4 has no effect.
- key_ready=0 for 20 cycles after 4th word -> core_data_valid stays 0, s_ready stays 0; pulse fires the cycle after key_ready&core_ready.
- m_ready held 0 for 10 cycles in DRAIN, then random -> m_data stable while stalled, exactly 4 words, busy falls after the 4th.
- TIMEOUT_CYCLES=8, core_result_valid never asserted -> err_timeout=1 eight cycles after launch, back in FILL with s_ready=1. Next block completes normally; err_timeout stays 1.
- CBC_EN: iv=000102..0f, two identical plaintext blocks -> the two ciphertexts differ. Decrypting both restores the plaintext. reset_n low mid-FILL -> all outputs at reset values.
